// File: rtl/grf_wb_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter: field widths,
// the zero-register constant and the MDU result FIFO entry layout.
package grf_wb_arbiter_pkg;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int PCW = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [PCW-1:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/grf_wb_fifo.sv
// DEPTH-entry synchronous FIFO for queued MDU results.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into an empty FIFO becomes visible at the head only on the next cycle.
module grf_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  fifo_entry_t r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];

  // Advance read/write pointers; reset empties the queue.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while the slot is not valid.
  always_ff @(posedge Clock) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline writeback has priority, MDU results are
// queued and drained on idle write-port cycles. A per-register scoreboard
// tracks MDU destinations still in flight and drives the decode stall.
// Optional trace output is enabled by defining GRF_ARB_TRACE_EN.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           wb_valid,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  input  logic [PCW-1:0] wb_pc,
  input  logic           mdu_issue,
  input  logic [AW-1:0]  mdu_issue_addr,
  output logic           issue_ok,
  input  logic           mdu_valid,
  output logic           mdu_ready,
  input  logic [AW-1:0]  mdu_addr,
  input  logic [DW-1:0]  mdu_data,
  input  logic [PCW-1:0] mdu_pc,
  input  logic [AW-1:0]  dec_ra1,
  input  logic [AW-1:0]  dec_ra2,
  input  logic [AW-1:0]  dec_wa,
  output logic           stall,
  output logic           RegWrite,
  output logic [AW-1:0]  WA,
  output logic [DW-1:0]  WD,
  output logic [PCW-1:0] WPC
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]   r_outstanding;
  logic [NREG-1:0] r_busy;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_issue_acc;
  fifo_entry_t     w_head;
  fifo_entry_t     w_push_entry;
  logic [NREG-1:0] w_busy_next;

  assign issue_ok     = !r_busy[mdu_issue_addr] && (r_outstanding < DEPTH_C);
  assign w_issue_acc  = mdu_issue && issue_ok;
  assign mdu_ready    = !w_full;
  assign w_push       = mdu_valid && !w_full;
  assign w_pop        = !wb_valid && !w_empty;
  assign w_push_entry = '{addr: mdu_addr, data: mdu_data, pc: mdu_pc};

  // Register 0 is never marked busy, but the explicit guard keeps it obvious.
  assign stall = ((dec_ra1 != ZERO_REG) && r_busy[dec_ra1]) ||
                 ((dec_ra2 != ZERO_REG) && r_busy[dec_ra2]) ||
                 ((dec_wa  != ZERO_REG) && r_busy[dec_wa]);

  grf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scoreboard next-state: clear on pop first, then set on issue, so a
  // same-register clear/set pair leaves the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) w_busy_next[w_head.addr] = 1'b0;
    if (w_issue_acc && (mdu_issue_addr != ZERO_REG))
      w_busy_next[mdu_issue_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge Clock) begin
    if (Reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  // Count MDU operations issued but not yet written back (includes $0).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue_acc, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Write-port select: writeback first, then FIFO head; idle holds fields.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RegWrite <= 1'b0;
      WA       <= '0;
      WD       <= '0;
      WPC      <= '0;
    end else if (wb_valid) begin
      RegWrite <= (wb_addr != ZERO_REG);
      WA       <= wb_addr;
      WD       <= wb_data;
      WPC      <= wb_pc;
    end else if (w_pop) begin
      RegWrite <= (w_head.addr != ZERO_REG);
      WA       <= w_head.addr;
      WD       <= w_head.data;
      WPC      <= w_head.pc;
    end else begin
      RegWrite <= 1'b0;
    end
  end

`ifdef GRF_ARB_TRACE_EN
  // Simulation trace of selected writes and protocol violations.
  always @(posedge Clock) begin
    if (!Reset) begin
      if (wb_valid && (wb_addr != ZERO_REG))
        $display("[%0t] WB  pc=%08h $%0d <= %08h", $time, wb_pc, wb_addr, wb_data);
      else if (w_pop && (w_head.addr != ZERO_REG))
        $display("[%0t] MDU pc=%08h $%0d <= %08h", $time, w_head.pc, w_head.addr, w_head.data);
      if (mdu_valid && w_full)
        $display("[%0t] ERROR: MDU push while result FIFO full", $time);
      if (mdu_issue && !issue_ok)
        $display("[%0t] ERROR: illegal MDU issue to $%0d", $time, mdu_issue_addr);
    end
  end
`endif

endmodule
